// File: rtl/bus_dma_if.sv
// Bus initiator/target signal bundle for bus_dma: one request channel
// (req/we/addr/be/wdata, accepted on ack) plus a single read response.
interface bus_dma_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_bo;
  logic [3:0]  bus_be_bo;
  logic [31:0] bus_wdata_bo;
  logic        bus_ack_i;
  logic        bus_resp_i;
  logic [31:0] bus_rdata_bi;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
    input  bus_ack_i, bus_resp_i, bus_rdata_bi
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
    output bus_ack_i, bus_resp_i, bus_rdata_bi
  );
endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA: reads len words from src and writes them to dst, one read in flight.
// Optional read-response timeout enabled by defining BUS_DMA_TIMEOUT_EN.
module bus_dma #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_left_o,
  bus_dma_if.master   bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] left_q, left_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
`ifdef BUS_DMA_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
`endif

  logic unused_lsbs;
  assign unused_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    left_d  = left_q;
    err_d   = err_q;
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
`ifdef BUS_DMA_TIMEOUT_EN
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        src_d   = {src_addr_i[31:2], 2'b00};
        dst_d   = {dst_addr_i[31:2], 2'b00};
        left_d  = len_i;
        err_d   = 1'b0;
        state_d = (len_i == 16'd0) ? DONE : RD_REQ;
      end
      RD_REQ: if (bus.bus_ack_i) state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.bus_resp_i) begin
          wdata_d = bus.bus_rdata_bi;
          state_d = WR_REQ;
        end
`ifdef BUS_DMA_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end
      WR_REQ: if (bus.bus_ack_i) begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        left_d  = left_q - 16'd1;
        state_d = (left_q == 16'd1) ? DONE : RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus fields are registered from the next state so they are glitch-free and
    // naturally hold through stalls and idle states.
    case (state_d)
      RD_REQ: begin
        req_d  = 1'b1;
        we_d   = 1'b0;
        addr_d = src_d;
        be_d   = 4'hF;
      end
      WR_REQ: begin
        req_d  = 1'b1;
        we_d   = 1'b1;
        addr_d = dst_d;
        be_d   = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
`ifdef BUS_DMA_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      left_q  <= left_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
`ifdef BUS_DMA_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = (state_q == DONE);
  assign err_o            = err_q;
  assign words_left_o     = left_q;
  assign bus.bus_req_o    = req_q;
  assign bus.bus_we_o     = we_q;
  assign bus.bus_addr_bo  = addr_q;
  assign bus.bus_be_bo    = be_q;
  assign bus.bus_wdata_bo = wdata_q;

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: table of directed copies plus random copies against a
// word-list model, a stalling/latency-controlled slave, reset and timeout sequences.
module tb_bus_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] len = '0;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_left_o;

  bus_dma_if bif();

  bus_dma #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .words_left_o(words_left_o), .bus(bif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a, input int m);
    if (m == 1) return a;
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  // Slave: ack after ack_dly stall cycles, response resp_dly cycles after read accept.
  int ack_dly = 0, resp_dly = 0, mem_mode = 0, stall = 0, rcnt = 0;
  bit resp_en = 1, pend = 0, active = 0;
  logic [31:0] cap_addr, cap_wdata, raddr;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic [31:0] rd_q[$], wa_q[$], wd_q[$];

  always @(negedge clk) begin
    if (rst) begin
      bif.bus_ack_i = 1'b0; bif.bus_resp_i = 1'b0;
      pend = 0; active = 0;
    end else begin
      bif.bus_resp_i  = 1'b0;
      bif.bus_rdata_bi = $urandom;
      if (bif.bus_ack_i) begin
        if (cap_we) begin wa_q.push_back(cap_addr); wd_q.push_back(cap_wdata); end
        else begin
          rd_q.push_back(cap_addr);
          if (resp_en) begin pend = 1; rcnt = 0; raddr = cap_addr; end
        end
        active = 0;
        bif.bus_ack_i = 1'b0;
      end
      if (pend) begin
        if (rcnt >= resp_dly) begin
          bif.bus_resp_i = 1'b1; bif.bus_rdata_bi = memf(raddr, mem_mode); pend = 0;
        end else rcnt++;
      end
      if (bif.bus_req_o) begin
        if (!active) begin
          cap_addr = bif.bus_addr_bo; cap_we = bif.bus_we_o;
          cap_be = bif.bus_be_bo; cap_wdata = bif.bus_wdata_bo;
          active = 1; stall = 0;
          chk("req_be", 32'(bif.bus_be_bo), 32'hF);
        end else begin
          chk("stall_addr", bif.bus_addr_bo, cap_addr);
          chk("stall_we", 32'(bif.bus_we_o), 32'(cap_we));
          chk("stall_be", 32'(bif.bus_be_bo), 32'(cap_be));
          if (cap_we) chk("stall_wdata", bif.bus_wdata_bo, cap_wdata);
        end
        if (stall >= ack_dly) bif.bus_ack_i = 1'b1;
        else stall++;
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, 32'(bif.bus_req_o), 0);
    chk({nm, "_we"}, 32'(bif.bus_we_o), 0);
    chk({nm, "_addr"}, bif.bus_addr_bo, 0);
    chk({nm, "_be"}, 32'(bif.bus_be_bo), 0);
    chk({nm, "_wdata"}, bif.bus_wdata_bo, 0);
    chk({nm, "_busy"}, 32'(busy_o), 0);
    chk({nm, "_done"}, 32'(done_o), 0);
    chk({nm, "_err"}, 32'(err_o), 0);
    chk({nm, "_left"}, 32'(words_left_o), 0);
  endtask

  // One copy; expected transfers come from the word-list model below.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input int a, input int r, input int m, input int lat,
                          input logic [31:0] w0);
    int t0, tdone, nbusy;
    bit seen;
    logic [31:0] ea;
    ack_dly = a; resp_dly = r; mem_mode = m;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1; t0 = cyc;
    nbusy = 0; seen = 0; tdone = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      // Garbage starts while busy must be ignored and inputs must already be latched.
      if (k < 2 && l != 0) begin
        start = 1'b1; src = $urandom; dst = $urandom; len = 16'($urandom);
      end else start = 1'b0;
      if (busy_o) nbusy++;
      if (done_o) begin seen = 1; tdone = cyc; end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    chk("latency", 32'(tdone - t0), 32'(lat));
    chk("busy_cycles", 32'(nbusy), 32'(lat));
    @(negedge clk);
    chk("done_width", 32'(done_o), 0);
    chk("busy_after", 32'(busy_o), 0);
    chk("words_left", 32'(words_left_o), 0);
    chk("err_clean", 32'(err_o), 0);
    chk("n_reads", 32'(rd_q.size()), 32'(l));
    chk("n_writes", 32'(wa_q.size()), 32'(l));
    for (int i = 0; i < int'(l); i++) begin
      ea = {s[31:2], 2'b00} + 32'(4 * i);
      if (i < rd_q.size()) chk("rd_addr", rd_q[i], ea);
      if (i < wa_q.size()) begin
        chk("wr_addr", wa_q[i], {d[31:2], 2'b00} + 32'(4 * i));
        chk("wr_data", wd_q[i], memf(ea, m));
      end
    end
    if (l != 0 && wd_q.size() > 0) chk("wr_data0", wd_q[0], w0);
  endtask

  typedef struct {
    logic [31:0] s, d;
    logic [15:0] l;
    int          a, r, m, lat;
    logic [31:0] w0;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int t0, ndone, a, r, l;
    bit seen;
    bif.bus_ack_i = 1'b0; bif.bus_resp_i = 1'b0; bif.bus_rdata_bi = '0;

    tbl[0] = '{32'h100, 32'h200, 16'd1, 0, 0, 0, 4, 32'hDEADBEEF};
    tbl[1] = '{32'h100, 32'h200, 16'd0, 0, 0, 0, 1, 32'h0};
    tbl[2] = '{32'h100, 32'h200, 16'd4, 3, 0, 1, 37, 32'h100};
    tbl[3] = '{32'hFFFFFFF8, 32'h300, 16'd3, 0, 0, 1, 10, 32'hFFFFFFF8};
    tbl[4] = '{32'h103, 32'h202, 16'd2, 1, 2, 0, 15, 32'hDEADBEEF};
    tbl[5] = '{32'hFFFFFFF0, 32'hFFFFFFFC, 16'd2, 0, 0, 0, 7, 32'h0000000F};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      run_xfer(tbl[i].s, tbl[i].d, tbl[i].l, tbl[i].a, tbl[i].r, tbl[i].m, tbl[i].lat, tbl[i].w0);

    for (int n = 0; n < 25; n++) begin
      logic [31:0] rs, rd;
      rs = $urandom; rd = $urandom;
      l = int'($urandom_range(0, 5)); a = int'($urandom_range(0, 2)); r = int'($urandom_range(0, 2));
      run_xfer(rs, rd, 16'(l), a, r, 1, l * (2 * a + r + 3) + 1, memf({rs[31:2], 2'b00}, 1));
    end

    // Reset while waiting for a read response.
    ack_dly = 0; resp_dly = 20; mem_mode = 1;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    @(negedge clk);
    src = 32'h800; dst = 32'h900; len = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && rd_q.size() == 0; k++) @(negedge clk);
    chk("rst_reads_seen", 32'(rd_q.size()), 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("post_rst_req", 32'(bif.bus_req_o), 0);
        chk("post_rst_busy", 32'(busy_o), 0);
      end
      if (done_o) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 0);
    run_xfer(32'h40, 32'h80, 16'd2, 0, 0, 1, 7, 32'h40);

`ifdef BUS_DMA_TIMEOUT_EN
    resp_en = 0; ack_dly = 0;
    @(negedge clk);
    src = 32'h400; dst = 32'h500; len = 16'd3; start = 1'b1; t0 = cyc;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_o) begin
        seen = 1;
        chk("tmo_latency", 32'(cyc - t0), 18);
      end
    end
    if (!seen) chk("tmo_done_timeout", 0, 1);
    @(negedge clk);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_left", 32'(words_left_o), 3);
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", 32'(err_o), 1);
    resp_en = 1;
    run_xfer(32'h100, 32'h200, 16'd1, 0, 0, 0, 4, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
